// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode.
// Holds {inst, pc+4} pairs; a decode redirect drops every queued entry.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [W-1:0]               inst_F,
    input  logic [W-1:0]               pc_plus4_F,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               inst_D,
    output logic [W-1:0]               pc_plus4_D,
    output logic                       valid_D,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [2*W-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic           ovf_q, ovf_d;
    logic           push_acc;
    logic           pop_acc;
    logic [2*W-1:0] head;

    // Pointer MSB separates the full case from the empty case.
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);
    assign empty = (wptr_q == rptr_q);
    assign count = wptr_q - rptr_q;

    assign push_ready = !full;
    assign overflow   = ovf_q;

    assign push_acc = push_valid && !full && !flush;
    assign pop_acc  = pop && !empty && !flush;

    assign head       = mem_q[rptr_q[AW-1:0]];
    assign valid_D    = !empty;
    assign inst_D     = empty ? '0 : head[2*W-1:W];
    assign pc_plus4_D = empty ? '0 : head[W-1:0];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (flush) begin
            rptr_d = wptr_q;
        end else begin
            if (push_acc)
                wptr_d = wptr_q + PW'(1);
            if (pop_acc)
                rptr_d = rptr_q + PW'(1);
            if (push_valid && full)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is left uninitialised; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!reset && push_acc)
            mem_q[wptr_q[AW-1:0]] <= {inst_F, pc_plus4_F};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed plan then random traffic
// against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid;
    logic          push_ready;
    logic [W-1:0]  inst_F;
    logic [W-1:0]  pc_plus4_F;
    logic          pop;
    logic          flush;
    logic [W-1:0]  inst_D;
    logic [W-1:0]  pc_plus4_D;
    logic          valid_D;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;

    fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .inst_F     (inst_F),
        .pc_plus4_F (pc_plus4_F),
        .pop        (pop),
        .flush      (flush),
        .inst_D     (inst_D),
        .pc_plus4_D (pc_plus4_D),
        .valid_D    (valid_D),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int unsigned npass  = 0;
    int unsigned ntotal = 0;

    logic [63:0] mq[$];
    bit          movf;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("push_ready", 64'(push_ready), 64'(n != DEPTH));
        chk("valid_D", 64'(valid_D), 64'(n != 0));
        chk("inst_D", 64'(inst_D), (n != 0) ? 64'(mq[0][63:32]) : 64'd0);
        chk("pc_plus4_D", 64'(pc_plus4_D),
            (n != 0) ? 64'(mq[0][31:0]) : 64'd0);
        chk("overflow", 64'(overflow), 64'(movf));
    endtask

    task automatic step(input logic pv, input logic [W-1:0] ins,
                        input logic [W-1:0] pc, input logic pp,
                        input logic fl, input logic rs);
        bit do_push, do_pop;
        push_valid = pv;
        inst_F     = ins;
        pc_plus4_F = pc;
        pop        = pp;
        flush      = fl;
        reset      = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            movf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            do_push = pv && (mq.size() < DEPTH);
            do_pop  = pp && (mq.size() > 0);
            if (pv && mq.size() == DEPTH)
                movf = 1'b1;
            if (do_pop)
                void'(mq.pop_front());
            if (do_push)
                mq.push_back({ins, pc});
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] d;
        movf = 1'b0;

        // Reset for two cycles, then release.
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle();

        // Fill to full.
        step(1'b1, 32'h11111111, 32'h4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 32'h8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33333333, 32'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h44444444, 32'h10, 1'b0, 1'b0, 1'b0);

        // Push while full sets the sticky overflow.
        step(1'b1, 32'h55555555, 32'h14, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h55555555, 32'h14, 1'b0, 1'b0, 1'b0);

        // Drain in order, then one pop on empty.
        for (int i = 0; i < 5; i++)
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Steady push+pop at count 2 across the pointer wrap.
        step(1'b1, 32'hA0000001, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hA0000002, 32'h104, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'hB0000000 + i, 32'h200 + 4 * i,
                 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush at count 3 with a wrong-path push and a pop.
        step(1'b1, 32'hC0000001, 32'h300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC0000002, 32'h304, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC0000003, 32'h308, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEADBEEF, 32'h30C, 1'b1, 1'b1, 1'b0);
        idle();

        // Reset beats simultaneous push and pop.
        step(1'b1, 32'hD0000001, 32'h400, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD0000002, 32'h404, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD0000003, 32'h408, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hAAAAAAAA, 32'h500, 1'b0, 1'b0, 1'b0);
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            step(1'($urandom_range(0, 3) != 0), d, $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
